// File: rtl/drac_pkg.sv
// Shared execute-stage types: ALU opcodes, 64-bit bus, and the divider's
// state encoding plus its result-correction helper.
package drac_pkg;

  typedef logic [63:0] bus64_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_MUL,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } div_state_t;

  localparam int DIV_ITERATIONS = 64;

  function automatic logic is_div_op(alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_div_op(alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(alu_op_t op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // Apply the sign flags captured at accept and pick quotient or remainder.
  function automatic bus64_t div_result(alu_op_t op, bus64_t quo, bus64_t rem,
                                        logic neg_quo, logic neg_rem);
    bus64_t q;
    bus64_t r;
    q = neg_quo ? (~quo + 64'd1) : quo;
    r = neg_rem ? (~rem + 64'd1) : rem;
    return is_rem_op(op) ? r : q;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dividend_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             quo_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One extra bit of headroom so the borrow is always visible in the top bit.
  always_comb begin
    shifted   = {rem_i, dividend_msb_i};
    diff      = shifted - {2'b00, divisor_i};
    quo_bit_o = ~diff[WIDTH+1];
    rem_o     = quo_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU; stalls the
// pipeline while iterating and returns a one-cycle result pulse.
module div_unit
  import drac_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             kill_i,
  input  logic             request_i,
  input  alu_op_t          alu_op_i,
  input  logic [WIDTH-1:0] data_rs1_i,
  input  logic [WIDTH-1:0] data_rs2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             stall_o,
  output div_state_t       dbg_state_o
);

  // Handshake: an operation is taken on a clock edge where the unit is IDLE,
  // request_i=1, kill_i=0 and alu_op_i is a divide op; stall_o then stays high
  // until the result cycle, in which valid_o=1 for exactly one cycle and
  // result_o carries the value. kill_i drops the operation with no valid_o.

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  alu_op_t          op_q, op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             sgn;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] step_quo;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i          (rem_q),
    .dividend_msb_i (quo_q[WIDTH-1]),
    .divisor_i      (dvs_q),
    .rem_o          (step_rem),
    .quo_bit_o      (step_bit)
  );

  // The dividend register shifts out its MSB each step and collects quotient bits.
  assign step_quo = {quo_q[WIDTH-2:0], step_bit};

  always_comb begin
    accept    = (state_q == IDLE) && request_i && !kill_i && is_div_op(alu_op_i);
    sgn       = is_signed_div_op(alu_op_i);
    abs_a     = (sgn && data_rs1_i[WIDTH-1]) ? (~data_rs1_i + 1'b1) : data_rs1_i;
    abs_b     = (sgn && data_rs2_i[WIDTH-1]) ? (~data_rs2_i + 1'b1) : data_rs2_i;

    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    result_d  = '0;
    valid_o   = 1'b0;
    stall_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o   = 1'b1;
          op_d      = alu_op_i;
          neg_quo_d = sgn && (data_rs1_i[WIDTH-1] ^ data_rs2_i[WIDTH-1]);
          neg_rem_d = sgn && data_rs1_i[WIDTH-1];
          quo_d     = abs_a;
          dvs_d     = abs_b;
          rem_d     = '0;
          cnt_d     = 7'(DIV_ITERATIONS);
          if (data_rs2_i == '0) begin
            state_d  = DONE;
            result_d = is_rem_op(alu_op_i) ? data_rs1_i : '1;
          end else if (sgn && (data_rs1_i == INT_MIN) && (data_rs2_i == '1)) begin
            state_d  = DONE;
            result_d = is_rem_op(alu_op_i) ? '0 : data_rs1_i;
          end else begin
            state_d  = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        stall_o = 1'b1;
        rem_d   = step_rem;
        quo_d   = step_quo;
        cnt_d   = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_d  = DONE;
          result_d = div_result(op_q, step_quo, step_rem[WIDTH-1:0], neg_quo_q, neg_rem_q);
        end
      end
      DONE: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over everything, including the result cycle.
    if (kill_i) begin
      state_d  = IDLE;
      valid_o  = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= ALU_ADD;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
    end
  end

  assign result_o    = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV64M cases, special cases,
// kill/reset behaviour, back-to-back spacing and random operands.
module tb_div_unit;
  import drac_pkg::*;

  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        rstn_i;
  logic        kill_i;
  logic        request_i;
  alu_op_t     alu_op_i;
  logic [63:0] data_rs1_i;
  logic [63:0] data_rs2_i;
  logic [63:0] result_o;
  logic        valid_o;
  logic        stall_o;
  div_state_t  dbg_state_o;

  int checks;
  int errors;

  div_unit #(.WIDTH(64)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .kill_i      (kill_i),
    .request_i   (request_i),
    .alu_op_i    (alu_op_i),
    .data_rs1_i  (data_rs1_i),
    .data_rs2_i  (data_rs2_i),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .stall_o     (stall_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the RISC-V M-extension rules.
  function automatic logic [63:0] ref_div(alu_op_t op, logic [63:0] a, logic [63:0] b);
    longint sa;
    longint sb;
    sa = a;
    sb = b;
    if (b == 64'd0) return (op == ALU_REM || op == ALU_REMU) ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if ((op == ALU_DIV || op == ALU_REM) && a == INT_MIN && b == 64'hFFFF_FFFF_FFFF_FFFF)
      return (op == ALU_REM) ? 64'd0 : a;
    case (op)
      ALU_DIV:  return 64'(sa / sb);
      ALU_REM:  return 64'(sa % sb);
      ALU_DIVU: return a / b;
      default:  return a % b;
    endcase
  endfunction

  function automatic int ref_latency(alu_op_t op, logic [63:0] a, logic [63:0] b);
    if (b == 64'd0) return 1;
    if ((op == ALU_DIV || op == ALU_REM) && a == INT_MIN && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return INT_MIN;
      4: return 64'($urandom_range(1, 200));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic alu_op_t rand_div_op();
    case ($urandom_range(0, 3))
      0: return ALU_DIV;
      1: return ALU_DIVU;
      2: return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

  // driver: starts at a falling edge (cycle 0), returns at the falling edge after DONE
  task automatic run_op(input string name, input alu_op_t op, input logic [63:0] a,
                        input logic [63:0] b);
    logic [63:0] exp_res;
    int          exp_lat;
    bit          seen;
    exp_res    = ref_div(op, a, b);
    exp_lat    = ref_latency(op, a, b);
    request_i  = 1'b1;
    alu_op_i   = op;
    data_rs1_i = a;
    data_rs2_i = b;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_cycle0 got %b want 1", name, stall_o);
    end
    seen = 1'b0;
    for (int n = 1; n <= 80 && !seen; n++) begin
      @(negedge clk);
      request_i = 1'b0;
      if (valid_o === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (n != exp_lat) begin
          errors++;
          $display("FAIL %s latency got %0d want %0d", name, n, exp_lat);
        end
        checks++;
        if (result_o !== exp_res) begin
          errors++;
          $display("FAIL %s result got %h want %h (a=%h b=%h)", name, result_o, exp_res, a, b);
        end
        checks++;
        if (stall_o !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_done got %b want 0", name, stall_o);
        end
      end else begin
        checks++;
        if (stall_o !== 1'b1) begin
          errors++;
          $display("FAIL %s stall_busy cycle %0d got %b want 1", name, n, stall_o);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout no valid_o within 80 cycles", name);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL %s after_done valid=%b result=%h want 0/0", name, valid_o, result_o);
    end
  endtask

  task automatic test_reset();
    rstn_i     = 1'b0;
    kill_i     = 1'b0;
    request_i  = 1'b0;
    alu_op_i   = ALU_ADD;
    data_rs1_i = '0;
    data_rs2_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || stall_o !== 1'b0 || result_o !== 64'd0 || dbg_state_o !== IDLE) begin
      errors++;
      $display("FAIL reset_values valid=%b stall=%b result=%h state=%0d want 0/0/0/IDLE",
               valid_o, stall_o, result_o, dbg_state_o);
    end
    rstn_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("divu_100_7", ALU_DIVU, 64'd100, 64'd7);
    run_op("remu_100_7", ALU_REMU, 64'd100, 64'd7);
    run_op("div_m100_7", ALU_DIV, -64'd100, 64'd7);
    run_op("rem_m100_7", ALU_REM, -64'd100, 64'd7);
    run_op("div_100_m7", ALU_DIV, 64'd100, -64'd7);
    run_op("rem_m100_m7", ALU_REM, -64'd100, -64'd7);
  endtask

  task automatic test_special();
    run_op("divu_by0", ALU_DIVU, 64'd5, 64'd0);
    run_op("rem_by0", ALU_REM, 64'd5, 64'd0);
    run_op("div_ovf", ALU_DIV, INT_MIN, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("rem_ovf", ALU_REM, INT_MIN, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divu_min_m1", ALU_DIVU, INT_MIN, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic test_nondiv_ignored();
    request_i  = 1'b1;
    alu_op_i   = ALU_ADD;
    data_rs1_i = 64'd9;
    data_rs2_i = 64'd3;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL nondiv_stall got %b want 0", stall_o);
    end
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0 || dbg_state_o !== IDLE) begin
        errors++;
        $display("FAIL nondiv_idle cycle %0d valid=%b state=%0d want 0/IDLE", n, valid_o, dbg_state_o);
      end
    end
    request_i = 1'b0;
  endtask

  task automatic test_kill_with_request();
    request_i  = 1'b1;
    kill_i     = 1'b1;
    alu_op_i   = ALU_DIVU;
    data_rs1_i = 64'd50;
    data_rs2_i = 64'd5;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_req_stall got %b want 0", stall_o);
    end
    @(negedge clk);
    request_i = 1'b0;
    kill_i    = 1'b0;
    checks++;
    if (dbg_state_o !== IDLE || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_req_noaccept state=%0d valid=%b want IDLE/0", dbg_state_o, valid_o);
    end
  endtask

  task automatic test_kill();
    request_i  = 1'b1;
    alu_op_i   = ALU_DIVU;
    data_rs1_i = 64'd123456789;
    data_rs2_i = 64'd1000;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      request_i = 1'b0;
    end
    kill_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_c30 stall=%b valid=%b want 1/0", stall_o, valid_o);
    end
    @(negedge clk);
    kill_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || valid_o !== 1'b0 || dbg_state_o !== IDLE) begin
      errors++;
      $display("FAIL kill_c31 stall=%b valid=%b state=%0d want 0/0/IDLE", stall_o, valid_o, dbg_state_o);
    end
    run_op("after_kill", ALU_DIVU, 64'd100, 64'd7);

    // kill in the result cycle suppresses the pulse
    request_i  = 1'b1;
    alu_op_i   = ALU_DIVU;
    data_rs1_i = 64'd5;
    data_rs2_i = 64'd0;
    @(negedge clk);
    request_i = 1'b0;
    kill_i    = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_done valid got %b want 0", valid_o);
    end
    @(negedge clk);
    kill_i = 1'b0;
    checks++;
    if (dbg_state_o !== IDLE || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_done_idle state=%0d valid=%b want IDLE/0", dbg_state_o, valid_o);
    end
  endtask

  task automatic test_reset_mid_op();
    request_i  = 1'b1;
    alu_op_i   = ALU_DIV;
    data_rs1_i = -64'd999;
    data_rs2_i = 64'd13;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      request_i = 1'b0;
    end
    rstn_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || stall_o !== 1'b0 || result_o !== 64'd0 || dbg_state_o !== IDLE) begin
      errors++;
      $display("FAIL reset_divide valid=%b stall=%b result=%h state=%0d want 0/0/0/IDLE",
               valid_o, stall_o, result_o, dbg_state_o);
    end
    @(negedge clk);
    rstn_i = 1'b1;
    // reset during the result cycle clears the registered result
    request_i  = 1'b1;
    alu_op_i   = ALU_REM;
    data_rs1_i = 64'd77;
    data_rs2_i = 64'd0;
    @(negedge clk);
    request_i = 1'b0;
    rstn_i    = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || result_o !== 64'd0 || dbg_state_o !== IDLE) begin
      errors++;
      $display("FAIL reset_done valid=%b result=%h state=%0d want 0/0/IDLE", valid_o, result_o, dbg_state_o);
    end
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    run_op("after_reset", ALU_REMU, 64'd1000, 64'd33);
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q[$];
    logic [63:0] a2;
    logic [63:0] b2;
    int          valid_cycles[$];
    a2 = {$urandom(), $urandom()};
    b2 = 64'($urandom_range(1, 1000));
    exp_q.push_back(ref_div(ALU_DIVU, 64'd1000, 64'd9));
    exp_q.push_back(ref_div(ALU_REM, a2, b2));
    request_i  = 1'b1;
    alu_op_i   = ALU_DIVU;
    data_rs1_i = 64'd1000;
    data_rs2_i = 64'd9;
    for (int n = 1; n <= 200 && exp_q.size() != 0; n++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        valid_cycles.push_back(n);
        checks++;
        if (result_o !== exp_q[0]) begin
          errors++;
          $display("FAIL b2b_result got %h want %h", result_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
        alu_op_i   = ALU_REM;
        data_rs1_i = a2;
        data_rs2_i = b2;
        if (exp_q.size() == 0) request_i = 1'b0;
      end
    end
    request_i = 1'b0;
    checks++;
    if (valid_cycles.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d pulses want 2", valid_cycles.size());
    end else begin
      checks++;
      if (valid_cycles[0] != 65 || valid_cycles[1] - valid_cycles[0] != 66) begin
        errors++;
        $display("FAIL b2b_spacing first=%0d gap=%0d want 65/66", valid_cycles[0],
                 valid_cycles[1] - valid_cycles[0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    alu_op_t     op;
    logic [63:0] a;
    logic [63:0] b;
    for (int i = 0; i < 40; i++) begin
      op = rand_div_op();
      a  = rand_operand();
      b  = rand_operand();
      run_op($sformatf("rand%0d", i), op, a, b);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_special();
    test_nondiv_ignored();
    test_kill_with_request();
    test_kill();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
